// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares one sample/done adder among NUM_REQ requesters.
// Define ADD_ARB_TIMEOUT_EN to bound the wait for the adder's done rise by TIMEOUT cycles.
module add_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*W-1:0]       req_a,
    input  logic [NUM_REQ*W-1:0]       req_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [W:0]                 rsp_sum,
    output logic                       rsp_err,
    output logic [W-1:0]               add_a,
    output logic [W-1:0]               add_b,
    output logic                       add_sample,
    input  logic [W:0]                 add_s,
    input  logic                       add_done
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("add_share_arbiter: NUM_REQ must be 2..8 and TIMEOUT positive");
    end

    logic [1:0]     state;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    logic           done_q;
    logic           rise;

    assign rise = add_done & ~done_q;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        win   = rr;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(rr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

`ifdef ADD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr         <= IDW'(NUM_REQ - 1);
            done_q     <= 1'b0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            add_a      <= '0;
            add_b      <= '0;
            add_sample <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            done_q <= add_done;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        add_a      <= req_a[win*W +: W];
                        add_b      <= req_b[win*W +: W];
                        add_sample <= 1'b1;
                        gnt        <= NUM_REQ'(1) << win;
                        rr         <= win;
                        rsp_id     <= win;
                        state      <= S_ISSUE;
                    end
                end
                // Done-rise detection is skipped here so a stale done level is masked.
                S_ISSUE: begin
                    add_sample <= 1'b0;
                    gnt        <= '0;
`ifdef ADD_ARB_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (rise) begin
                        rsp_sum   <= add_s;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
`ifdef ADD_ARB_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a behavioural one-cycle sample/done adder.
// Timeout steps run only when ADD_ARB_TIMEOUT_EN is defined.
module tb_add_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_sum;
    logic        rsp_err;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_sample;
    logic [4:0]  add_s = '0;
    logic        add_done = 1'b0;

    logic        pend = 1'b0;
    logic [4:0]  sum_r = '0;
    logic        stuck = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gcyc = 0;

    add_share_arbiter #(.NUM_REQ(4), .W(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_err(rsp_err), .add_a(add_a), .add_b(add_b), .add_sample(add_sample),
        .add_s(add_s), .add_done(add_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adder: captures on sample, raises done one cycle later, drops done on the next sample.
    always @(posedge clk) begin
        if (add_sample) begin
            add_done <= 1'b0;
            sum_r    <= {1'b0, add_a} + {1'b0, add_b};
            pend     <= 1'b1;
        end else if (pend) begin
            pend     <= 1'b0;
            add_s    <= sum_r;
            add_done <= !stuck;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    task automatic run_txn(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input logic [4:0] exp_sum, input logic [3:0] drop);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0 && n < 20);
        chk({tag, "_gnt"}, gnt, exp_gnt);
        chk({tag, "_sample"}, add_sample, 1'b1);
        gcyc = cyc;
        req = req & ~drop;
        tick();
        chk({tag, "_sample_clr"}, add_sample, 1'b0);
        chk({tag, "_gnt_clr"}, gnt, 4'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && !rsp_err && n < 40);
        chk({tag, "_latency"}, cyc - gcyc, 3);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_id"}, rsp_id, exp_id);
        chk({tag, "_sum"}, rsp_sum, exp_sum);
        tick();
        chk({tag, "_valid_clr"}, rsp_valid, 1'b0);
    endtask

    logic [3:0] rr_gnt [8];
    logic [4:0] rr_sum [4];
    int prev_g;
    int seen;
    int terr;
    int n;

    initial begin
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rr_sum = '{5'd3, 5'd17, 5'd16, 5'd12};

        // Reset state
        repeat (3) tick();
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_id", rsp_id, 2'd0);
        chk("rst_sum", rsp_sum, 5'd0);
        chk("rst_ops", {add_a, add_b}, 8'h00);
        chk("rst_sample", add_sample, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_gnt", gnt, 4'b0);

        // All four requesting: round-robin 0,1,2,3 twice at a 5-cycle period
        set_ops(0, 4'd1, 4'd2);
        set_ops(1, 4'd9, 4'd8);
        set_ops(2, 4'd15, 4'd1);
        set_ops(3, 4'd6, 4'd6);
        req = 4'b1111;
        prev_g = 0;
        for (int k = 0; k < 8; k++) begin
            run_txn($sformatf("rr%0d", k), rr_gnt[k], 2'(k % 4), rr_sum[k % 4], 4'b0000);
            if (k > 0) chk($sformatf("rr%0d_period", k), gcyc - prev_g, 5);
            prev_g = gcyc;
        end
        req = 4'b0000;

        // Single request, then 0101 with requester 0 just served (includes carry-out case)
        set_ops(0, 4'd3, 4'd4);
        set_ops(2, 4'd15, 4'd15);
        req = 4'b0001;
        run_txn("single", 4'b0001, 2'd0, 5'd7, 4'b0001);
        req = 4'b0101;
        run_txn("rr02_a", 4'b0100, 2'd2, 5'b11110, 4'b0100);
        run_txn("rr02_b", 4'b0001, 2'd0, 5'd7, 4'b0001);

        // Reset asserted at E2 of a transaction for requester 1
        req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0 && n < 20);
        chk("abort_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 4'b0);
        chk("async_sum", rsp_sum, 5'd0);
        chk("async_id", rsp_id, 2'd0);
        chk("async_ops", {add_a, add_b}, 8'h00);
        chk("async_sample", add_sample, 1'b0);
        chk("async_valid", rsp_valid, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid || gnt != 4'b0) seen++;
        end
        chk("abort_no_rsp", seen, 0);
        req = 4'b1001;
        run_txn("post_rst", 4'b0001, 2'd0, 5'd7, 4'b0001);
        run_txn("post_rst_b", 4'b1000, 2'd3, 5'd12, 4'b1000);

`ifdef ADD_ARB_TIMEOUT_EN
        // Adder never completes: error strobe at E1+16, next grant two cycles later
        stuck = 1'b1;
        req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 4'b0 && n < 20);
        chk("tmo_gnt", gnt, 4'b0100);
        gcyc = cyc;
        req = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_err && !rsp_valid && n < 40);
        chk("tmo_err", rsp_err, 1'b1);
        chk("tmo_valid", rsp_valid, 1'b0);
        chk("tmo_when", cyc - gcyc, 17);
        chk("tmo_id", rsp_id, 2'd2);
        terr = cyc;
        stuck = 1'b0;
        tick();
        chk("tmo_err_clr", rsp_err, 1'b0);
        req = 4'b0001;
        run_txn("tmo_next", 4'b0001, 2'd0, 5'd7, 4'b0001);
        chk("tmo_regrant", gcyc - terr, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer that shares one sample/done 4-bit adder unit among NUM_REQ requesters. Each requester presents operands with a level request. The block grants one requester, launches the adder with a single-cycle sample pulse, and waits for the adder's done rising edge. It then returns the sum tagged with the requester id. It sits between the requester ports and the adder datapath, which it drives directly.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- W, 4: operand width; sum is W+1
- TIMEOUT, 16: WAIT-cycle limit; used only with the timeout feature
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester level request
- req_a  in  NUM_REQ*W  operand a; requester i occupies bits [i*W +: W]
- req_b  in  NUM_REQ*W  operand b; same packing as req_a
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  $clog2(NUM_REQ)  index of the requester the result belongs to
- rsp_sum  out  W+1  result
- rsp_err  out  1  one-cycle timeout strobe
- add_a, add_b  out  W  operands driven to the adder
- add_sample  out  1  adder launch pulse
- add_s  in  W+1  adder sum
- add_done  in  1  adder completion level

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - outputs: gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_sum=0, add_a=0, add_b=0, add_sample=0
  - internal: done_q=0, rr pointer=NUM_REQ-1
- IDLE with req!=0:
  - Winner is the first set bit searching upward from rr+1, with wrap-around.
  - Register add_a/add_b from the winner's slice; set add_sample=1; set gnt=onehot(winner).
  - Update rr to winner; store rsp_id=winner; go to ISSUE.
- IDLE with req==0: stay in IDLE; all strobes stay 0.
- ISSUE: clear add_sample and gnt; go to WAIT. add_a/add_b hold until the next grant.
- WAIT:
  - done_q samples add_done every cycle, in every state.
  - A rise is add_done=1 and done_q=0, and is evaluated only in WAIT.
  - On a rise: register rsp_sum=add_s and rsp_valid=1; go to RESP.
- RESP: clear rsp_valid; go to IDLE.
- Requester rules:
  - A requester holds req and its operands stable until it sees gnt.
  - It may drop req in the gnt cycle or later.
  - A requester that drops req before being granted is not served and keeps no state.
- Arithmetic: rsp_sum is add_s passed through unmodified (W+1 bits, carry retained); the block performs no arithmetic.
- Reset mid-transaction: all state returns to reset values immediately.
  - The adder keeps no reset and may still complete.
  - A done rise arriving while in IDLE is ignored; no rsp_valid is produced.
- The adder's done level may be X or 1 before its first launch. Done-rise detection is skipped in ISSUE, which masks this.

## Timing
- E0: grant edge (IDLE to ISSUE). gnt and add_sample are high for cycle E0..E1.
- E1: the adder captures its operands.
- E2: the adder asserts done.
- E3: the block detects the rise; rsp_valid is high for cycle E3..E4.
- E4: RESP to IDLE. Earliest next grant is E5, giving one transaction per 5 cycles.
- Latency from grant to rsp_valid is 3 cycles with the standard adder. A longer adder latency stretches WAIT only.
- Requests arriving during ISSUE, WAIT or RESP wait until IDLE; they are not lost while req is held.
- Multiple simultaneous requests: exactly one grant per IDLE visit, chosen by round-robin priority.

## Configuration
- ADD_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT without a done rise: rsp_err=1 for one cycle with rsp_id held, rsp_valid stays 0, and the FSM goes to RESP, then IDLE.
- Not defined: the counter is absent, rsp_err is tied to 0, and WAIT is unbounded.

## Test plan
- Single request, req=0001, a=3, b=4 → gnt=0001 at E0; add_sample high one cycle; rsp_valid at E3 with rsp_id=0, rsp_sum=7.
- Overflow case, a=15, b=15 → rsp_sum=30 (5'b11110).
- req=1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3; one gnt bit per transaction; period 5 cycles.
- req=0101 with requester 0 just served → next gnt=0100, then 0001.
- rst_n low at E2 of a transaction → all outputs 0 asynchronously; no rsp_valid follows; next request after release is granted to requester 0.
- With ADD_ARB_TIMEOUT_EN and TIMEOUT=16, add_done stuck at 0 → rsp_err pulse at cycle E1+16 with correct rsp_id, no rsp_valid, FSM back in IDLE two cycles later.
